dmem_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between two masters.
- Master 0 is the CPU data port. Master 1 is the loader/DMA port, used for boot image load and debug peek/poke.
- Sits between the core's data interface (dce/daddr/we/din/dm) and the ram instance.
- Grants one access per cycle, returns read data with the RAM's 1-cycle latency, and guarantees master 1 forward progress.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_starve.sv | 31 +++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and defaults for the data-RAM arbiter between the CPU and
// loader/DMA masters.
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_LOCK1 = 1'b1
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    localparam int MAX_WAIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve.sv
// Master 1 starvation guard: counts consecutive denied cycles and raises
// force_m1 once the count reaches MAX_WAIT.
module dmem_arb_starve
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic m1_req,
    input  logic m1_gnt,
    output logic force_m1
);

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != MAX_W8) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign force_m1 = m1_req && (wait_cnt == MAX_W8);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU (m0) vs loader/DMA (m1) with m1 lock and
// starvation guard. Define DMEM_ARB_RR_EN for a round-robin IDLE tie-break.
//
// state    | meaning
// ---------+------------------------------------------
// ST_IDLE  | no owner; per-cycle priority arbitration
// ST_LOCK1 | m1 owns the RAM while m1_lock is held
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    input  logic          m1_lock,
    output logic          mem_ena,
    output logic [3:0]    mem_wea,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_dina,
    input  logic [31:0]   mem_douta
);

    state_t      state, state_nxt;
    logic        force_m1;
    logic        gnt0, gnt1;
    logic        pick_m0;
    logic [1:0]  rd_owner;
    logic [31:0] m0_rdata_q, m1_rdata_q;

    dmem_arb_starve #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .m1_req   (m1_req),
        .m1_gnt   (gnt1),
        .force_m1 (force_m1)
    );

`ifdef DMEM_ARB_RR_EN
    // last_winner=1 means m1 won most recently, so m0 takes the next tie.
    logic last_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= 1'b1;
        end else if (gnt0) begin
            last_winner <= 1'b0;
        end else if (gnt1) begin
            last_winner <= 1'b1;
        end
    end

    assign pick_m0 = last_winner;
`else
    assign pick_m0 = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt1 && m1_lock) state_nxt = ST_LOCK1;
            ST_LOCK1: if (!m1_lock)        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (force_m1) begin
                        gnt1 = 1'b1;
                    end else if (m0_req && m1_req) begin
                        gnt0 = pick_m0;
                        gnt1 = !pick_m0;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
                ST_LOCK1: gnt1 = m1_req;
            endcase
        end
    end

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    assign mem_ena  = gnt0 | gnt1;
    assign mem_wea  = gnt1 ? m1_we : (gnt0 ? m0_we : 4'b0000);
    assign mem_addr = gnt1 ? m1_addr : m0_addr;
    assign mem_dina = gnt1 ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
        end else if (gnt0 && (m0_we == 4'b0000)) begin
            rd_owner <= OWN_M0;
        end else if (gnt1 && (m1_we == 4'b0000)) begin
            rd_owner <= OWN_M1;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    // Capture returned data so each master's rdata holds between its reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
        end else begin
            if (rd_owner[0]) m0_rdata_q <= mem_douta;
            if (rd_owner[1]) m1_rdata_q <= mem_douta;
        end
    end

    assign m0_rvalid = rd_owner[0];
    assign m1_rvalid = rd_owner[1];
    assign m0_rdata  = rd_owner[0] ? mem_douta : m0_rdata_q;
    assign m1_rdata  = rd_owner[1] ? mem_douta : m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int AW       = 10;
    localparam int MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req, m1_lock;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          mem_ena;
    logic [3:0]    mem_wea;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dina, mem_douta;

    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;
    logic [31:0]   ram [0:1023];
    logic [31:0]   ref_mem [0:31];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_lock   (m1_lock),
        .mem_ena   (mem_ena),
        .mem_wea   (mem_wea),
        .mem_addr  (mem_addr),
        .mem_dina  (mem_dina),
        .mem_douta (mem_douta)
    );

    // Synchronous single-port RAM with byte enables and a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_ena) begin
            if (mem_wea == 4'b0000) mem_douta <= ram[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_wea[b]) ram[mem_addr][8*b +: 8] <= mem_dina[8*b +: 8];
        end
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst = 1; idle_inputs(); next_cycle(); rst = 0;
    endtask

    task automatic preload();
        logic [31:0] v;
        bd_we = 1;
        for (int i = 0; i < 32; i++) begin
            v = (i == 5) ? 32'hDEADBEEF : ((i >= 16) ? $urandom : 32'd0);
            bd_addr = AW'(i); bd_data = v; ref_mem[i] = v;
            next_cycle();
        end
        bd_we = 0;
    endtask

    task automatic test_reset();
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b0) $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); else passed++;
        total++; if (m1_gnt !== 1'b0) $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); else passed++;
        total++; if (mem_ena !== 1'b0) $display("FAIL rst_mem_ena: got %b want 0", mem_ena); else passed++;
        total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); else passed++;
        total++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) $display("FAIL rst_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata); else passed++;
        next_cycle();
        rst = 0; idle_inputs();
    endtask

    task automatic test_m0_read();
        m0_req = 1; m0_we = 0; m0_addr = 5;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL rd_gnt: got %b%b want 10", m0_gnt, m1_gnt); else passed++;
        total++; if (mem_ena !== 1'b1 || mem_addr !== AW'(5)) $display("FAIL rd_mem: got ena %b addr %0d want 1 5", mem_ena, mem_addr); else passed++;
        total++; if (m0_rvalid !== 1'b0) $display("FAIL rd_early_rvalid: got %b want 0", m0_rvalid); else passed++;
        next_cycle(); m0_req = 0;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %b want 1", m0_rvalid); else passed++;
        total++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h want deadbeef", m0_rdata); else passed++;
        total++; if (m1_rvalid !== 1'b0) $display("FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b0) $display("FAIL rd_rvalid_pulse: got %b want 0", m0_rvalid); else passed++;
        total++; if (m0_rdata !== 32'hDEADBEEF) $display("FAIL rd_hold: got %h want deadbeef", m0_rdata); else passed++;
        next_cycle();
    endtask

    task automatic test_starvation();
        logic e1;
        m0_req = 1; m0_we = 0; m0_addr = 5;
        m1_req = 1; m1_we = 0; m1_addr = 5;
        for (int i = 0; i < 18; i++) begin
            e1 = (i == 8) || (i == 17);
            @(negedge clk);
            total++; if (m1_gnt !== e1 || m0_gnt !== !e1)
                $display("FAIL starve_cycle%0d: got m0 %b m1 %b want m0 %b m1 %b", i, m0_gnt, m1_gnt, !e1, e1);
            else passed++;
            next_cycle();
        end
        idle_inputs(); next_cycle();
    endtask

    task automatic test_round_robin();
        logic e0;
        pulse_reset();
        m0_req = 1; m0_we = 0; m0_addr = 5;
        m1_req = 1; m1_we = 0; m1_addr = 5;
        for (int i = 0; i < 8; i++) begin
            e0 = (i % 2) == 0;
            @(negedge clk);
            total++; if (m0_gnt !== e0 || m1_gnt !== !e0)
                $display("FAIL rr_cycle%0d: got m0 %b m1 %b want m0 %b m1 %b", i, m0_gnt, m1_gnt, e0, !e0);
            else passed++;
            next_cycle();
        end
        idle_inputs(); next_cycle();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 4; i++) begin
            m1_req = 1; m1_we = 4'hF; m1_addr = AW'(i); m1_wdata = 32'(i + 1); m1_lock = (i != 3);
            m0_req = (i != 0); m0_we = 0; m0_addr = 0;
            @(negedge clk);
            total++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0)
                $display("FAIL lock_beat%0d: got m0 %b m1 %b want m0 0 m1 1", i, m0_gnt, m1_gnt);
            else passed++;
            next_cycle();
        end
        m1_req = 0; m1_lock = 0; m1_we = 0;
        for (int k = 0; k < 5; k++) begin
            m0_req = (k < 4); m0_we = 0; m0_addr = AW'(k);
            @(negedge clk);
            if (k < 4) begin
                total++; if (m0_gnt !== 1'b1) $display("FAIL lock_after_gnt%0d: got %b want 1", k, m0_gnt); else passed++;
            end
            if (k > 0) begin
                total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'(k))
                    $display("FAIL lock_readback%0d: got v%b %h want v1 %h", k - 1, m0_rvalid, m0_rdata, 32'(k));
                else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_byte_write();
        m0_req = 1; m0_we = 4'b0010; m0_addr = 7; m0_wdata = 32'hFFFFABFF;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1 || mem_wea !== 4'b0010) $display("FAIL bw_write: got gnt %b wea %b want 1 0010", m0_gnt, mem_wea); else passed++;
        next_cycle();
        m0_we = 0;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b0) $display("FAIL bw_write_rvalid: got %b want 0", m0_rvalid); else passed++;
        next_cycle();
        m0_req = 0;
        @(negedge clk);
        total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000AB00) $display("FAIL bw_readback: got v%b %h want v1 0000ab00", m0_rvalid, m0_rdata); else passed++;
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        m1_req = 1; m1_we = 0; m1_addr = 2; m1_lock = 1;
        @(negedge clk);
        total++; if (m1_gnt !== 1'b1) $display("FAIL rmr_gnt: got %b want 1", m1_gnt); else passed++;
        next_cycle();
        rst = 1; m0_req = 1;
        #1;
        total++; if (m1_rvalid !== 1'b0) $display("FAIL rmr_rvalid_async: got %b want 0", m1_rvalid); else passed++;
        @(negedge clk);
        total++; if ({m0_gnt, m1_gnt, mem_ena} !== 3'b000) $display("FAIL rmr_gnts: got %b want 000", {m0_gnt, m1_gnt, mem_ena}); else passed++;
        total++; if (m1_rdata !== 32'd0) $display("FAIL rmr_rdata: got %h want 0", m1_rdata); else passed++;
        next_cycle();
        rst = 0; idle_inputs(); m0_req = 1; m0_addr = 0;
        @(negedge clk);
        total++; if (m0_gnt !== 1'b1) $display("FAIL rmr_idle_after: got %b want 1", m0_gnt); else passed++;
        next_cycle(); idle_inputs(); next_cycle();
    endtask

    task automatic test_random();
        bit locked, hold0, hold1, e0, e1, pend0, pend1;
        int wcnt;
        logic [31:0] pdata0, pdata1, exp_rd0, exp_rd1;
`ifdef DMEM_ARB_RR_EN
        bit m1_won_last;
        m1_won_last = 1;
`endif
        pulse_reset();
        locked = 0; hold0 = 0; hold1 = 0; pend0 = 0; pend1 = 0; wcnt = 0;
        pdata0 = 0; pdata1 = 0; exp_rd0 = 0; exp_rd1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold0) begin
                m0_req = ($urandom % 3) != 0;
                m0_we = ($urandom % 2) ? 4'($urandom) : 4'b0000;
                m0_addr = AW'(16 + $urandom % 16);
                m0_wdata = $urandom;
            end
            if (!hold1) begin
                m1_req = ($urandom % 2) != 0;
                m1_we = ($urandom % 2) ? 4'($urandom) : 4'b0000;
                m1_addr = AW'(16 + $urandom % 16);
                m1_wdata = $urandom;
                m1_lock = locked ? (($urandom % 4) != 0) : (($urandom % 6) == 0);
            end
            if (locked) begin
                e0 = 0; e1 = m1_req;
            end else if (m1_req && wcnt == MAX_WAIT) begin
                e0 = 0; e1 = 1;
            end else if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
                e0 = m1_won_last;
`else
                e0 = 1;
`endif
                e1 = !e0;
            end else begin
                e0 = m0_req; e1 = m1_req;
            end
            if (pend0) exp_rd0 = pdata0;
            if (pend1) exp_rd1 = pdata1;
            @(negedge clk);
            total++; if (m0_gnt !== e0 || m1_gnt !== e1)
                $display("FAIL rand%0d_gnt: got m0 %b m1 %b want m0 %b m1 %b", n, m0_gnt, m1_gnt, e0, e1);
            else passed++;
            total++; if (mem_ena !== (e0 | e1)) $display("FAIL rand%0d_ena: got %b want %b", n, mem_ena, e0 | e1); else passed++;
            if (e0 | e1) begin
                total++; if (mem_addr !== (e1 ? m1_addr : m0_addr) || mem_wea !== (e1 ? m1_we : m0_we))
                    $display("FAIL rand%0d_route: got addr %0d wea %b", n, mem_addr, mem_wea);
                else passed++;
            end
            total++; if (m0_rvalid !== pend0 || m0_rdata !== exp_rd0)
                $display("FAIL rand%0d_m0_rd: got v%b %h want v%b %h", n, m0_rvalid, m0_rdata, pend0, exp_rd0);
            else passed++;
            total++; if (m1_rvalid !== pend1 || m1_rdata !== exp_rd1)
                $display("FAIL rand%0d_m1_rd: got v%b %h want v%b %h", n, m1_rvalid, m1_rdata, pend1, exp_rd1);
            else passed++;
            pend0 = e0 && (m0_we == 4'b0000);
            pend1 = e1 && (m1_we == 4'b0000);
            pdata0 = ref_mem[m0_addr[4:0]];
            pdata1 = ref_mem[m1_addr[4:0]];
            for (int b = 0; b < 4; b++) begin
                if (e0 && m0_we[b]) ref_mem[m0_addr[4:0]][8*b +: 8] = m0_wdata[8*b +: 8];
                if (e1 && m1_we[b]) ref_mem[m1_addr[4:0]][8*b +: 8] = m1_wdata[8*b +: 8];
            end
            wcnt = (m1_req && !e1) ? ((wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT) : 0;
            locked = locked ? m1_lock : (e1 && m1_lock);
`ifdef DMEM_ARB_RR_EN
            if (e0) m1_won_last = 0;
            else if (e1) m1_won_last = 1;
`endif
            hold0 = m0_req && !e0;
            hold1 = m1_req && !e1;
            next_cycle();
        end
        idle_inputs(); next_cycle(); next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; bd_we = 0; bd_addr = 0; bd_data = 0;
        idle_inputs();
        #1;
        preload();
        test_reset();
        test_m0_read();
`ifdef DMEM_ARB_RR_EN
        test_round_robin();
`else
        test_starvation();
`endif
        test_lock_burst();
        test_byte_write();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
